// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier built around booth_substep.
// Operands arrive through an in_valid/in_ready handshake, the product leaves
// through an out_valid/out_ready handshake.
// Optional configuration macro: BOOTH_TWO_STEP_EN chains two substeps per
// clock, halving the number of compute cycles with bit-identical results.

// One radix-2 Booth step: conditional add/subtract of the multiplicand into
// the accumulator, then an arithmetic right shift of {acc, q, q_m1}.
module booth_substep #(
    parameter int W = 9
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] q,
    input  logic         q_m1,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc_next,
    output logic [W-1:0] q_next,
    output logic         q_m1_next
);

    logic [W-1:0] sum;

    // Booth recoding of the pair {q[0], q_m1} followed by the arithmetic shift
    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + b;
            2'b10:   sum = acc - b;
            default: sum = acc;
        endcase
        acc_next  = {sum[W-1], sum[W-1:1]};
        q_next    = {sum[0], q[W-1:1]};
        q_m1_next = q[0];
    end

endmodule

module booth_mul_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    // The datapath is one bit wider than the operands so that acc - B cannot
    // overflow when b is the most negative value. The two-step build rounds
    // the width up to even so every cycle performs exactly two steps.
`ifdef BOOTH_TWO_STEP_EN
    localparam int W   = ((N % 2) == 1) ? (N + 1) : (N + 2);
    localparam int SPC = 2;
`else
    localparam int W   = N + 1;
    localparam int SPC = 1;
`endif
    localparam int STEPS = W;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - SPC);
    localparam logic [CW-1:0] CNT_INC  = CW'(SPC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [W-1:0]  acc_r;
    logic [W-1:0]  q_r;
    logic          q_m1_r;
    logic [W-1:0]  b_r;
    logic [CW-1:0] cnt_r;

    logic load;
    logic step;

    logic [W-1:0] acc_s1;
    logic [W-1:0] q_s1;
    logic         q_m1_s1;

    logic [W-1:0] acc_step;
    logic [W-1:0] q_step;
    logic         q_m1_step;

    booth_substep #(.W(W)) u_step1 (
        .acc       (acc_r),
        .q         (q_r),
        .q_m1      (q_m1_r),
        .b         (b_r),
        .acc_next  (acc_s1),
        .q_next    (q_s1),
        .q_m1_next (q_m1_s1)
    );

`ifdef BOOTH_TWO_STEP_EN
    // The second substep consumes the first one's results in the same cycle
    booth_substep #(.W(W)) u_step2 (
        .acc       (acc_s1),
        .q         (q_s1),
        .q_m1      (q_m1_s1),
        .b         (b_r),
        .acc_next  (acc_step),
        .q_next    (q_step),
        .q_m1_next (q_m1_step)
    );
`else
    assign acc_step  = acc_s1;
    assign q_step    = q_s1;
    assign q_m1_step = q_m1_s1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode; the handshake outputs depend on state only
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture on acceptance, then one (or two) Booth steps per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r  <= '0;
            q_r    <= '0;
            q_m1_r <= 1'b0;
            b_r    <= '0;
            cnt_r  <= '0;
        end else if (load) begin
            acc_r  <= '0;
            q_r    <= {{(W-N){a[N-1]}}, a};
            q_m1_r <= 1'b0;
            b_r    <= {{(W-N){b[N-1]}}, b};
            cnt_r  <= '0;
        end else if (step) begin
            acc_r  <= acc_step;
            q_r    <= q_step;
            q_m1_r <= q_m1_step;
            cnt_r  <= cnt_r + CNT_INC;
        end
    end

    // The top 2W-2N bits of {acc, q} are sign extension only and are dropped
    assign product = (2*N)'({acc_r, q_r});

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed vector table plus hand-written sequences for
// stall, mid-operation reset and back-to-back operation of booth_mul_seq.
module tb_booth_mul_seq;

    localparam int N = 8;
`ifdef BOOTH_TWO_STEP_EN
    localparam int C = 5;
`else
    localparam int C = 9;
`endif
    localparam int TIMEOUT = 50;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        logic signed [N-1:0] a;
        logic signed [N-1:0] b;
        logic [2*N-1:0]      expected;
    } vec_t;

    vec_t vecs[12];

    booth_mul_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure acceptance spacing
    always @(posedge clk) cyc <= cyc + 1;

    // Compare one value against its expectation and log any failure
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer operands in IDLE, let them be accepted, then wait for out_valid.
    // Leaves the DUT in DONE; lat is the number of edges after acceptance.
    task automatic applyStimulus(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                 output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < TIMEOUT) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        lat      = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Complete the output handshake with a single out_ready cycle
    task automatic releaseOutput();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int viol;
        int guard;
        int acc_cyc[4];
        logic [2*N-1:0] held;
        logic [2*N-1:0] ref_prod;
        logic signed [N-1:0] ra;
        logic signed [N-1:0] rb;
        logic signed [N-1:0] bb_a[4];
        logic signed [N-1:0] bb_b[4];
        logic [2*N-1:0] bb_exp[4];

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0]  = '{a:  8'sd3,    b: -8'sd5,   expected: 16'hFFF1};
        vecs[1]  = '{a: -8'sd128,  b: -8'sd128, expected: 16'h4000};
        vecs[2]  = '{a: -8'sd128,  b:  8'sd127, expected: 16'hC080};
        vecs[3]  = '{a:  8'sd127,  b:  8'sd127, expected: 16'h3F01};
        vecs[4]  = '{a:  8'sd0,    b: -8'sd77,  expected: 16'h0000};
        vecs[5]  = '{a:  8'sd6,    b:  8'sd7,   expected: 16'h002A};
        vecs[6]  = '{a: -8'sd1,    b: -8'sd1,   expected: 16'h0001};
        vecs[7]  = '{a: -8'sd7,    b:  8'sd9,   expected: 16'hFFC1};
        vecs[8]  = '{a:  8'sd100,  b: -8'sd3,   expected: 16'hFED4};
        vecs[9]  = '{a:  8'sd127,  b: -8'sd128, expected: 16'hC080};
        vecs[10] = '{a:  8'sd1,    b: -8'sd128, expected: 16'hFF80};
        vecs[11] = '{a: -8'sd77,   b:  8'sd0,   expected: 16'h0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset product", 32'(product), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table with latency check
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d product", i), 32'(product), 32'(vecs[i].expected));
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(C));
            releaseOutput();
            checkOutput($sformatf("vec%0d idle after", i), 32'(in_ready), 32'd1);
        end

        // Output stall: DONE held for 20 cycles with an in_valid pulse in the window
        applyStimulus(8'sd3, -8'sd5, lat);
        held = product;
        checkOutput("stall product", 32'(held), 32'hFFF1);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                in_valid = 1'b1;
                a        = 8'd9;
                b        = 8'd9;
            end
            if (i == 6) in_valid = 1'b0;
            @(posedge clk); #1;
            if (product !== held || out_valid !== 1'b1 || in_ready !== 1'b0) viol++;
        end
        checkOutput("stall stability", 32'(viol), 32'd0);
        releaseOutput();
        checkOutput("stall pulse ignored in_ready", 32'(in_ready), 32'd1);
        checkOutput("stall pulse ignored out_valid", 32'(out_valid), 32'd0);

        // Reset asserted on the 4th RUN cycle abandons the operation
        in_valid = 1'b1;
        a        = 8'd50;
        b        = 8'd50;
        @(posedge clk); #1;
        in_valid = 1'b0;
        viol     = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) viol++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset product", 32'(product), 32'd0);
        repeat (C + 2) begin
            @(posedge clk); #1;
            if (out_valid) viol++;
        end
        checkOutput("midreset no out_valid", 32'(viol), 32'd0);
        applyStimulus(8'sd6, 8'sd7, lat);
        checkOutput("after reset product", 32'(product), 32'h002A);
        checkOutput("after reset latency", 32'(lat), 32'(C));
        releaseOutput();

        // Back-to-back with in_valid held high and out_ready held high
        bb_a[0] = 8'sd12;   bb_b[0] = 8'sd11;   bb_exp[0] = 16'h0084;
        bb_a[1] = -8'sd2;   bb_b[1] = 8'sd64;   bb_exp[1] = 16'hFF80;
        bb_a[2] = -8'sd128; bb_b[2] = -8'sd1;   bb_exp[2] = 16'h0080;
        bb_a[3] = 8'sd15;   bb_b[3] = -8'sd15;  bb_exp[3] = 16'hFF1F;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a     = bb_a[k];
            b     = bb_b[k];
            guard = 0;
            while (!in_ready && guard < TIMEOUT) begin
                @(posedge clk); #1;
                guard++;
            end
            acc_cyc[k] = cyc;
            @(posedge clk); #1;
            lat = 0;
            while (!out_valid && lat < TIMEOUT) begin
                @(posedge clk); #1;
                lat++;
            end
            checkOutput($sformatf("b2b%0d product", k), 32'(product), 32'(bb_exp[k]));
            if (k > 0) begin
                checkOutput($sformatf("b2b%0d spacing", k), 32'(acc_cyc[k] - acc_cyc[k-1]),
                            32'(C + 2));
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Random sweep against the signed reference product
        for (int i = 0; i < 200; i++) begin
            ra       = N'($urandom);
            rb       = N'($urandom);
            ref_prod = (2*N)'(32'(ra) * 32'(rb));
            applyStimulus(ra, rb, lat);
            checkOutput($sformatf("rand%0d %0d*%0d", i, ra, rb), 32'(product), 32'(ref_prod));
            releaseOutput();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
